// File: rtl/instr_fetch.sv
// Purpose : instruction fetch stage; latches pc, issues one bus read, returns the word to decode.
// Latency : fetch_start -> bus_start 1 cycle, bus_done -> instr_valid 1 cycle (3 cycles minimum end to end).
// Backpress: no queueing; fetch_start is only accepted in IDLE, busy is high while a fetch is outstanding.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   pc, fetch_start     - word address to fetch and its request strobe (sampled in IDLE)
//   flush               - abandon the current fetch; an issued read is drained silently
//   bus_addr, bus_start - read address (held until the next request) and one-cycle read strobe
//   bus_q, bus_done     - read data, valid in the bus_done cycle
//   instr, instr_valid  - fetched word (held) and its one-cycle update pulse
//   fetch_err           - pulses with instr_valid when the fetch was faulted
//   busy                - high whenever a fetch is in progress
//
// Optional build macro FETCH_TIMEOUT_EN: aborts a bus wait after TIMEOUT cycles without bus_done.

module instr_fetch #(
   parameter logic [26:0] ADDR_LIMIT  = 27'h7FFFFFF,
   parameter logic [31:0] FAULT_INSTR = 32'h0000_0000,
   parameter logic [15:0] TIMEOUT     = 16'd1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [26:0] pc,
   input  logic        fetch_start,
   input  logic        flush,
   output logic [26:0] bus_addr,
   output logic        bus_start,
   input  logic [31:0] bus_q,
   input  logic        bus_done,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        fetch_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_DRAIN = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   load_data;    // capture bus_q into instr next cycle
   logic   load_fault;   // capture FAULT_INSTR and raise fetch_err next cycle
   logic   tmo_hit;      // bus wait expired

`ifdef FETCH_TIMEOUT_EN
   logic [15:0] tmo_cnt;
   logic        in_bus_wait;
   logic        enter_bus_wait;

   assign in_bus_wait    = (state == S_WAIT) || (state == S_DRAIN);
   assign enter_bus_wait = ((state_nxt == S_WAIT) || (state_nxt == S_DRAIN)) && (state_nxt != state);
   assign tmo_hit        = in_bus_wait && !bus_done && (tmo_cnt == TIMEOUT - 16'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (enter_bus_wait) begin
         tmo_cnt <= '0;
      end else if (in_bus_wait && !bus_done) begin
         tmo_cnt <= tmo_cnt + 16'd1;
      end
   end
`else
   // Without the timeout the bus wait is unbounded; TIMEOUT is intentionally inert.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign tmo_hit        = 1'b0;
`endif

   // Next-state and capture decisions
   always_comb begin
      state_nxt  = state;
      load_data  = 1'b0;
      load_fault = 1'b0;
      case (state)
         S_IDLE: begin
            // A fetch request colliding with flush is dropped outright.
            if (fetch_start && !flush) begin
               state_nxt = (pc < ADDR_LIMIT) ? S_REQ : S_FAULT;
            end
         end
         S_REQ: begin
            // Strobe is already on the bus, so a flush here must still drain the read.
            state_nxt = flush ? S_DRAIN : S_WAIT;
         end
         S_WAIT: begin
            if (bus_done) begin
               state_nxt = S_IDLE;
               load_data = !flush;
            end else if (flush) begin
               state_nxt = S_DRAIN;
            end else if (tmo_hit) begin
               state_nxt  = S_IDLE;
               load_fault = 1'b1;
            end
         end
         S_DRAIN: begin
            if (bus_done || tmo_hit) begin
               state_nxt = S_IDLE;
            end
         end
         S_FAULT: begin
            state_nxt  = S_IDLE;
            load_fault = !flush;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         bus_addr    <= '0;
         bus_start   <= 1'b0;
         instr       <= FAULT_INSTR;
         instr_valid <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         state       <= state_nxt;
         // REQ is only entered from IDLE, so the strobe can never repeat back to back.
         bus_start   <= (state_nxt == S_REQ);
         if ((state == S_IDLE) && (state_nxt == S_REQ)) begin
            bus_addr <= pc;
         end
         instr_valid <= load_data || load_fault;
         fetch_err   <= load_fault;
         if (load_data) begin
            instr <= bus_q;
         end else if (load_fault) begin
            instr <= FAULT_INSTR;
         end
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_instr_fetch.sv
// Purpose : self-checking bench for instr_fetch with a scoreboard of expected fetch results.
// Latency : checks fetch_start->instr_valid, fault and timeout latencies against fixed cycle counts.
// Backpress: drives fetch_start held high to confirm single-issue behaviour.

module tb_instr_fetch;

   localparam logic [26:0] LIMIT = 27'h100;
   localparam logic [31:0] FI    = 32'h0000_0013;
   localparam logic [15:0] TMO   = 16'd8;

   logic        clk = 1'b0;
   logic        reset;
   logic [26:0] pc;
   logic        fetch_start;
   logic        flush;
   logic [26:0] bus_addr;
   logic        bus_start;
   logic [31:0] bus_q;
   logic        bus_done;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fetch_err;
   logic        busy;

   instr_fetch #(
      .ADDR_LIMIT (LIMIT),
      .FAULT_INSTR(FI),
      .TIMEOUT    (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .fetch_start(fetch_start),
      .flush      (flush),
      .bus_addr   (bus_addr),
      .bus_start  (bus_start),
      .bus_q      (bus_q),
      .bus_done   (bus_done),
      .instr      (instr),
      .instr_valid(instr_valid),
      .fetch_err  (fetch_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          n_valid = 0;
   int          n_start = 0;
   int          last_valid_cyc = 0;
   bit          prev_start = 1'b0;
   logic [32:0] exp_q[$];     // {fetch_err, instr}
   logic [26:0] addr_q[$];
   logic [32:0] e;
   logic [26:0] ea;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // Output monitor: pops the scoreboard on every instr_valid and every bus_start.
   always @(negedge clk) begin
      if (instr_valid) begin
         n_valid++;
         last_valid_cyc = cyc;
         if (exp_q.size() == 0) begin
            check("spurious_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("instr", instr, e[31:0]);
            check("fetch_err", 32'(fetch_err), 32'(e[32]));
            check("busy_at_valid", 32'(busy), 32'd0);
         end
      end else if (fetch_err) begin
         check("err_without_valid", 32'd1, 32'd0);
      end
      if (bus_start) begin
         n_start++;
         if (prev_start) check("start_back_to_back", 32'd1, 32'd0);
         if (addr_q.size() == 0) begin
            check("spurious_start", 32'd1, 32'd0);
         end else begin
            ea = addr_q.pop_front();
            check("bus_addr", 32'(bus_addr), 32'(ea));
         end
      end
      prev_start = bus_start;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus_start) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic start_fetch(input logic [26:0] a);
      pc          = a;
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
   endtask

   // Called in the first WAIT cycle; bus_done arrives after dly further cycles.
   task automatic respond(input int dly, input logic [31:0] d);
      repeat (dly) tick();
      bus_q    = d;
      bus_done = 1'b1;
      tick();
      bus_done = 1'b0;
   endtask

   task automatic fetch(input logic [26:0] a, input logic [31:0] d, input int dly);
      bit ok;
      int c0;
      exp_q.push_back({1'b0, d});
      addr_q.push_back(a);
      c0 = cyc;
      start_fetch(a);
      wait_start(ok);
      check("start_seen", 32'(ok), 32'd1);
      tick();
      respond(dly, d);
      tick();
      check("latency", 32'(last_valid_cyc - c0), 32'(3 + dly));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit          ok;
      int          s;
      int          r;
      int          nv;
      logic [31:0] prev;

      reset = 1'b1; pc = '0; fetch_start = 1'b0; flush = 1'b0;
      bus_q = '0; bus_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_instr", instr, FI);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_err", 32'(fetch_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bus_start", 32'(bus_start), 32'd0);
      check("rst_bus_addr", 32'(bus_addr), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // Normal fetches: bus_done 2 cycles after bus_start, then in the first WAIT cycle.
      fetch(27'h010, 32'hDEADBEEF, 1);
      repeat (3) tick();
      check("instr_hold", instr, 32'hDEADBEEF);
      fetch(27'h011, 32'hCAFEF00D, 0);
      tick();

      // Out-of-range pc: faulted two cycles later with no bus access.
      exp_q.push_back({1'b1, FI});
      s = n_start;
      pc = LIMIT;
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      @(negedge clk);
      check("fault_busy", 32'(busy), 32'd1);
      tick();
      @(negedge clk);
      check("fault_valid", 32'(instr_valid), 32'd1);
      tick();
      check("fault_no_bus", 32'(n_start - s), 32'd0);

      // Last valid address is fetched normally.
      fetch(LIMIT - 27'd1, 32'h0BADC0DE, 2);
      tick();
      prev = 32'h0BADC0DE;

      // Flush in WAIT, bus_done three cycles later is drained.
      addr_q.push_back(27'h020);
      start_fetch(27'h020);
      wait_start(ok);
      check("start_seen", 32'(ok), 32'd1);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      tick();
      bus_q = 32'h12345678;
      bus_done = 1'b1;
      @(negedge clk);
      check("drain_busy", 32'(busy), 32'd1);
      tick();
      bus_done = 1'b0;
      @(negedge clk);
      check("drain_idle", 32'(busy), 32'd0);
      check("drain_instr", instr, prev);
      tick();

      // Flush and bus_done together in WAIT: response discarded.
      addr_q.push_back(27'h021);
      start_fetch(27'h021);
      wait_start(ok);
      check("start_seen", 32'(ok), 32'd1);
      tick();
      flush = 1'b1;
      bus_done = 1'b1;
      bus_q = 32'h55555555;
      tick();
      flush = 1'b0;
      bus_done = 1'b0;
      @(negedge clk);
      check("flushdone_idle", 32'(busy), 32'd0);
      check("flushdone_instr", instr, prev);
      tick();

      // Flush in REQ: read still drained.
      addr_q.push_back(27'h022);
      start_fetch(27'h022);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      @(negedge clk);
      check("req_flush_drain", 32'(busy), 32'd1);
      tick();
      bus_q = 32'h66666666;
      bus_done = 1'b1;
      tick();
      bus_done = 1'b0;
      @(negedge clk);
      check("req_flush_idle", 32'(busy), 32'd0);
      tick();

      // fetch_start together with flush in IDLE is ignored.
      pc = 27'h030;
      fetch_start = 1'b1;
      flush = 1'b1;
      tick();
      fetch_start = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      check("start_flush_ignored", 32'(busy), 32'd0);
      tick();

      // Flush during FAULT suppresses valid/err.
      pc = 27'h200;
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("fault_flush_idle", 32'(busy), 32'd0);
      tick();
      tick();

      // fetch_start held high: one bus_start per completed fetch.
      s = n_start;
      addr_q.push_back(27'h040);
      addr_q.push_back(27'h040);
      exp_q.push_back({1'b0, 32'hA1A1A1A1});
      exp_q.push_back({1'b0, 32'hA2A2A2A2});
      pc = 27'h040;
      fetch_start = 1'b1;
      wait_start(ok);
      check("held_start1", 32'(ok), 32'd1);
      tick();
      respond(1, 32'hA1A1A1A1);
      wait_start(ok);
      check("held_start2", 32'(ok), 32'd1);
      tick();
      respond(0, 32'hA2A2A2A2);
      fetch_start = 1'b0;
      tick();
      tick();
      check("held_starts", 32'(n_start - s), 32'd2);
      prev = 32'hA2A2A2A2;

      // Reset in WAIT, stray bus_done afterwards.
      addr_q.push_back(27'h050);
      start_fetch(27'h050);
      wait_start(ok);
      check("start_seen", 32'(ok), 32'd1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("wrst_busy", 32'(busy), 32'd0);
      check("wrst_addr", 32'(bus_addr), 32'd0);
      check("wrst_instr", instr, FI);
      tick();
      bus_q = 32'h77777777;
      bus_done = 1'b1;
      tick();
      bus_done = 1'b0;
      @(negedge clk);
      check("stray_busy", 32'(busy), 32'd0);
      check("stray_instr", instr, FI);
      tick();

      // Bus never answers.
      addr_q.push_back(27'h060);
`ifdef FETCH_TIMEOUT_EN
      exp_q.push_back({1'b1, FI});
      start_fetch(27'h060);
      wait_start(ok);
      check("start_seen", 32'(ok), 32'd1);
      r = cyc;
      nv = n_valid;
      repeat (20) tick();
      check("tmo_pulses", 32'(n_valid - nv), 32'd1);
      check("tmo_latency", 32'(last_valid_cyc - r), 32'(TMO) + 32'd1);
      check("tmo_instr", instr, FI);
`else
      exp_q.push_back({1'b0, 32'hA5A5A5A5});
      start_fetch(27'h060);
      wait_start(ok);
      check("start_seen", 32'(ok), 32'd1);
      r = cyc;
      nv = n_valid;
      tick();
      repeat (30) tick();
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_no_valid", 32'(n_valid - nv), 32'd0);
      respond(0, 32'hA5A5A5A5);
      tick();
      check("wait_done", 32'(n_valid - nv), 32'd1);
      check("wait_instr", instr, 32'hA5A5A5A5);
      check("wait_started", 32'(r > 0), 32'd1);
`endif
      tick();

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      check("addr_q_empty", 32'(addr_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
